hilo_commit: RTL and testbench

Execute-to-writeback owner of the 64-bit HI/LO register pair. Captures the 64-bit result the execute ALU produces for mult/multu/div/divu/mthi/mtlo into a memory-stage pending slot. Commits it architecturally only when the instruction leaves memory without exception or flush. Drives the `hilo` operand back into execute, forwarding the pending value so back-to-back HI/LO producers and consumers stay correct.

---
 rtl/hilo_commit.sv | 78 +++++++
 tb/tb_hilo_commit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hilo_commit.sv
// HI/LO pending slot in memory stage with commit to architectural hilo_q on a clean memory exit.
// Optional macro HILO_FWD_EN forwards the pending value to execute; without it execute stalls on a read.
module hilo_commit #(
    parameter logic [63:0] RESET_HILO = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hilo_weE,
    input  logic        hilo_rdE,
    input  logic [63:0] aluoutE,
    input  logic        div_stallE,
    input  logic        flushE,
    input  logic        stallM,
    input  logic        flushM,
    input  logic        exceptM,
    output logic [63:0] hiloE,
    output logic [63:0] hilo_q,
    output logic        pend_validM,
    output logic        hilo_stallE
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    slot_t       slot_q;
    slot_t       slot_d;
    logic [63:0] pend_data;
    logic [63:0] pend_d;
    logic [63:0] hilo_d;
    logic        capture;

    assign pend_validM = (slot_q == FULL);

`ifdef HILO_FWD_EN
    assign hiloE       = pend_validM ? pend_data : hilo_q;
    assign hilo_stallE = 1'b0;
`else
    assign hiloE       = hilo_q;
    assign hilo_stallE = hilo_rdE & pend_validM;
`endif

    // A stalled execute instruction must not enter the slot; it re-presents after the drain.
    assign capture = hilo_weE & ~div_stallE & ~flushE & ~hilo_stallE;

    always_comb begin
        slot_d = slot_q;
        pend_d = pend_data;
        hilo_d = hilo_q;
        if (flushM || exceptM) begin
            slot_d = EMPTY;
        end else if (!stallM) begin
            if (slot_q == FULL) begin
                hilo_d = pend_data;
            end
            if (capture) begin
                slot_d = FULL;
                pend_d = aluoutE;
            end else begin
                slot_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q    <= EMPTY;
            pend_data <= 64'h0;
            hilo_q    <= RESET_HILO;
        end else begin
            slot_q    <= slot_d;
            pend_data <= pend_d;
            hilo_q    <= hilo_d;
        end
    end

endmodule

// File: tb/tb_hilo_commit.sv
// Directed bench for hilo_commit: vector table plus hand sequences for divide, hazard gating and reset.
module tb_hilo_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic        hilo_weE, hilo_rdE, div_stallE, flushE, stallM, flushM, exceptM;
    logic [63:0] aluoutE;
    logic [63:0] hiloE, hilo_q;
    logic        pend_validM, hilo_stallE;

    int n_cmp = 0;
    int n_bad = 0;

    hilo_commit #(.RESET_HILO(64'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .hilo_weE   (hilo_weE),
        .hilo_rdE   (hilo_rdE),
        .aluoutE    (aluoutE),
        .div_stallE (div_stallE),
        .flushE     (flushE),
        .stallM     (stallM),
        .flushM     (flushM),
        .exceptM    (exceptM),
        .hiloE      (hiloE),
        .hilo_q     (hilo_q),
        .pend_validM(pend_validM),
        .hilo_stallE(hilo_stallE)
    );

    always #5 clk = ~clk;

`ifdef HILO_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic        rd;
        logic [63:0] alu;
        logic [4:0]  ctl;      // {div_stallE, flushE, stallM, flushM, exceptM}
        logic [63:0] q;
        logic        pv;
        logic [63:0] he_fwd;
        logic [63:0] he_nofwd;
        logic        st_nofwd;
    } vec_t;

    function automatic vec_t v(input logic we, input logic rd, input logic [63:0] alu,
                               input logic [4:0] ctl, input logic [63:0] q, input logic pv,
                               input logic [63:0] hf, input logic [63:0] hn, input logic st);
        vec_t r;
        r.we = we; r.rd = rd; r.alu = alu; r.ctl = ctl;
        r.q = q; r.pv = pv; r.he_fwd = hf; r.he_nofwd = hn; r.st_nofwd = st;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hilo_weE = 0; hilo_rdE = 0; aluoutE = '0; div_stallE = 0;
        flushE = 0; stallM = 0; flushM = 0; exceptM = 0;
    endtask

    vec_t vecs[23];

    initial begin
        vecs[0]  = v(0, 0, 64'h0,                   5'b00000, 64'h0, 0, 64'h0, 64'h0, 0);
        vecs[1]  = v(1, 0, 64'h0000_0002_0000_0006, 5'b00000, 64'h0, 0, 64'h0, 64'h0, 0);
        vecs[2]  = v(0, 1, 64'h0,                   5'b00000, 64'h0, 1, 64'h0000_0002_0000_0006, 64'h0, 1);
        vecs[3]  = v(0, 1, 64'h0,                   5'b00000, 64'h0000_0002_0000_0006, 0,
                     64'h0000_0002_0000_0006, 64'h0000_0002_0000_0006, 0);
        vecs[4]  = v(1, 0, 64'hDEAD_BEEF_0000_0001, 5'b00000, 64'h0000_0002_0000_0006, 0,
                     64'h0000_0002_0000_0006, 64'h0000_0002_0000_0006, 0);
        vecs[5]  = v(0, 0, 64'h0,                   5'b00001, 64'h0000_0002_0000_0006, 1,
                     64'hDEAD_BEEF_0000_0001, 64'h0000_0002_0000_0006, 0);
        vecs[6]  = v(0, 0, 64'h0,                   5'b00000, 64'h0000_0002_0000_0006, 0,
                     64'h0000_0002_0000_0006, 64'h0000_0002_0000_0006, 0);
        vecs[7]  = v(0, 0, 64'h0,                   5'b00000, 64'h0000_0002_0000_0006, 0,
                     64'h0000_0002_0000_0006, 64'h0000_0002_0000_0006, 0);
        vecs[8]  = v(1, 0, 64'h1,                   5'b00000, 64'h0000_0002_0000_0006, 0,
                     64'h0000_0002_0000_0006, 64'h0000_0002_0000_0006, 0);
        vecs[9]  = v(1, 0, 64'h2,                   5'b00000, 64'h0000_0002_0000_0006, 1,
                     64'h1, 64'h0000_0002_0000_0006, 0);
        vecs[10] = v(0, 0, 64'h0,                   5'b00000, 64'h1, 1, 64'h2, 64'h1, 0);
        vecs[11] = v(0, 0, 64'h0,                   5'b00000, 64'h2, 0, 64'h2, 64'h2, 0);
        vecs[12] = v(1, 0, 64'h5,                   5'b00000, 64'h2, 0, 64'h2, 64'h2, 0);
        vecs[13] = v(0, 0, 64'h0,                   5'b00100, 64'h2, 1, 64'h5, 64'h2, 0);
        vecs[14] = v(0, 0, 64'h0,                   5'b00100, 64'h2, 1, 64'h5, 64'h2, 0);
        vecs[15] = v(0, 0, 64'h0,                   5'b00100, 64'h2, 1, 64'h5, 64'h2, 0);
        vecs[16] = v(0, 0, 64'h0,                   5'b00000, 64'h2, 1, 64'h5, 64'h2, 0);
        vecs[17] = v(0, 0, 64'h0,                   5'b00000, 64'h5, 0, 64'h5, 64'h5, 0);
        vecs[18] = v(1, 0, 64'h9,                   5'b01000, 64'h5, 0, 64'h5, 64'h5, 0);
        vecs[19] = v(0, 0, 64'h0,                   5'b00000, 64'h5, 0, 64'h5, 64'h5, 0);
        vecs[20] = v(1, 0, 64'h7,                   5'b00000, 64'h5, 0, 64'h5, 64'h5, 0);
        vecs[21] = v(1, 0, 64'h8,                   5'b00010, 64'h5, 1, 64'h7, 64'h5, 0);
        vecs[22] = v(0, 0, 64'h0,                   5'b00000, 64'h5, 0, 64'h5, 64'h5, 0);

        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
        check("reset hilo_q", hilo_q, 64'h0);
        check("reset hiloE", hiloE, 64'h0);
        check("reset pend_validM", {63'h0, pend_validM}, 64'h0);
        check("reset hilo_stallE", {63'h0, hilo_stallE}, 64'h0);

        for (int i = 0; i < 23; i++) begin
            hilo_weE = vecs[i].we;
            hilo_rdE = vecs[i].rd;
            aluoutE  = vecs[i].alu;
            {div_stallE, flushE, stallM, flushM, exceptM} = vecs[i].ctl;
            #1;
            check($sformatf("row%0d hilo_q", i), hilo_q, vecs[i].q);
            check($sformatf("row%0d pend_validM", i), {63'h0, pend_validM}, {63'h0, vecs[i].pv});
            check($sformatf("row%0d hiloE", i), hiloE, FWD ? vecs[i].he_fwd : vecs[i].he_nofwd);
            check($sformatf("row%0d hilo_stallE", i), {63'h0, hilo_stallE},
                  {63'h0, FWD ? 1'b0 : vecs[i].st_nofwd});
            tick();
        end

        // HI/LO writer that also reads while a write is pending: only the forwarding build captures.
        idle();
        hilo_weE = 1; aluoutE = 64'h11;
        tick();
        hilo_rdE = 1; aluoutE = 64'h22;
        #1;
        check("hazard stall", {63'h0, hilo_stallE}, {63'h0, !FWD});
        tick();
        idle();
        #1;
        check("hazard commit", hilo_q, 64'h11);
        check("hazard gated capture", {63'h0, pend_validM}, {63'h0, FWD});
        tick();
        check("hazard drain", hilo_q, FWD ? 64'h22 : 64'h11);

        // Divide: 33 busy cycles with the write asserted, then the result.
        idle();
        hilo_weE = 1; div_stallE = 1; aluoutE = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int c = 0; c < 33; c++) begin
            tick();
            if (c == 0 || c == 32) check($sformatf("div busy %0d pend", c), {63'h0, pend_validM}, 64'h0);
        end
        div_stallE = 0; aluoutE = 64'h0000_0001_0000_0003;
        tick();
        idle();
        #1;
        check("div captured", {63'h0, pend_validM}, 64'h1);
        check("div hiloE", hiloE, FWD ? 64'h0000_0001_0000_0003 : hilo_q);
        tick();
        check("div commit", hilo_q, 64'h0000_0001_0000_0003);
        check("div drained", {63'h0, pend_validM}, 64'h0);
        tick();
        check("div single capture", {63'h0, pend_validM}, 64'h0);

        // Reset while the slot is full and a divide is in flight.
        hilo_weE = 1; aluoutE = 64'hABC;
        tick();
        check("pre-reset full", {63'h0, pend_validM}, 64'h1);
        div_stallE = 1;
        rst = 1;
        tick();
        rst = 0;
        idle();
        #1;
        check("rst-full hilo_q", hilo_q, 64'h0);
        check("rst-full pend", {63'h0, pend_validM}, 64'h0);
        tick();
        check("rst-full no late commit", hilo_q, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
